ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised successor to the single-key arrow/space/esc decoder.
- Receives PS/2 frames directly, with synchronisation, parity and timeout.
- Decodes make/break/extended sequences and keeps a per-key held bitmap.
- Emits key-change events through a valid/ready handshake. Sits between the board PS/2 pins and the game control FSM.

Parameters:
NUM_KEYS, 8, number of tracked keys (1..8); takes the first NUM_KEYS entries of the key table
SYNC_STAGES, 2, synchroniser depth for PS2_CLK/PS2_DATA (min 2)
TIMEOUT_CYCLES, 100000, CLK cycles with no PS2_CLK falling edge before a partial frame is aborted
FIFO_DEPTH, 4, event FIFO depth (power of two, ≥2); used only with KBD_EVT_FIFO_EN

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
PS2_CLK  in  1  keyboard clock, asynchronous
PS2_DATA  in  1  keyboard data, asynchronous
key_down  out  NUM_KEYS  bit i high while key i is held
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when evt_valid&&evt_ready
evt_key  out  3  key index of event
evt_make  out  1  1 = press, 0 = release
frame_err  out  1  one-cycle pulse on parity, start/stop or timeout error
overflow  out  1  one-cycle pulse when an event is dropped

Behaviour:
- Key table (index: code): 0 UP E0 75, 1 DOWN E0 72, 2 LEFT E0 6B, 3 RIGHT E0 74, 4 SPACE 29, 5 ESC 76, 6 ENTER 5A, 7 P 4D. Arrow keys match only when the E0 prefix is present; keys 4-7 match only without it.
- Reset values: all outputs 0; frame FSM IDLE; prefix flags clear; event buffer empty.
- Input sampling: both inputs pass through SYNC_STAGES flops. A falling edge is synced PS2_CLK going 1 then 0; data is sampled in that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE -> DATA on an edge with data=0. An edge with data=1 is ignored.
  - DATA shifts 8 bits, LSB first.
  - PARITY checks odd parity over the data bits plus the parity bit.
  - STOP requires data=1.
  - A bad parity or stop bit discards the byte, pulses frame_err and returns to IDLE.
- Timeout: outside IDLE, TIMEOUT_CYCLES cycles without an edge -> IDLE, frame_err pulse, prefix flags cleared.
- Byte strobe: asserted the cycle after the stop-bit edge.
- Assembler, on each byte strobe:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte is looked up using (ext, byte), then ext and brk are cleared.
  - A parity/stop error also clears ext and brk.
- Make of key i (i<NUM_KEYS):
  - If key_down[i]==0: set it and push {i,1}.
  - If already set (typematic repeat): no event.
- Break of key i: if key_down[i]==1, clear it and push {i,0}; otherwise no event.
- Unmapped codes and indices ≥NUM_KEYS: ignored, no error.
- Latency: key_down and the push both take effect one cycle after the byte strobe (two cycles after the stop-bit edge).
- Event buffer, without the macro: single register.
  - A push while full and not popping in the same cycle drops the new event and pulses overflow.
  - A push and a pop in the same cycle are both accepted.
- key_down always reflects the true state, even when an event is dropped.
- evt_key/evt_make stay stable while evt_valid&&!evt_ready.

Optional Feature:
- Macro: KBD_EVT_FIFO_EN.
- Defined: the event buffer is a FIFO_DEPTH-entry FWFT FIFO.
  - evt_valid = !empty.
  - Push on full with no same-cycle pop: drop and pulse overflow.
  - Push on full with a same-cycle pop: accepted.
- Undefined: single-register buffer as in Behaviour; FIFO_DEPTH is unused.

Decomposition:
- Package kbd_pkg holds:
  - scan-code constants (E0, F0, key codes);
  - key index constants KEY_UP..KEY_P;
  - event width constant (4 bits: key + make);
  - frame-state encoding.
- Sub-module ps2_rx_frame holds the synchroniser, edge detect, frame FSM and timeout. It outputs a byte, a strobe and an error signal.

Test Plan:
- Frame 29 with good parity -> key_down[4]=1; evt {4,1} two cycles after the stop edge. Then F0,29 -> key_down[4]=0, evt {4,0}.
- E0,75 then E0,F0,75 -> events {0,1},{0,0}. Bare 75 (no E0) -> no event, key_down unchanged.
- 29 sent 3 times (typematic) -> exactly one {4,1} event.
- Frame 6B with a flipped parity bit -> frame_err pulse, no event. A following E0 then 6B -> {2,1}.
- Send 5 bits, then hold PS2_CLK high for TIMEOUT_CYCLES -> frame_err. A subsequent full frame 76 -> {5,1}.
- evt_ready=0, press 29 then 76:
  - single register: first event held, overflow pulse on the second;
  - with KBD_EVT_FIFO_EN and FIFO_DEPTH=4: both queued, none dropped.
  - Also: rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 key tracker: scan codes, key indices,
// event layout, frame-state encoding and the key-table lookup.
package kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ESC   = 3'd5;
  localparam logic [2:0] KEY_ENTER = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  localparam int EVT_W = 4;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_e;

  typedef struct packed {
    logic [2:0] key;
    logic       make;
  } kbd_evt_t;

  // Returns {hit, index}; arrows need the E0 prefix, the rest must lack it.
  function automatic logic [3:0] kbd_lookup(
    input logic       ext,
    input logic [7:0] code
  );
    logic [3:0] r;
    r = '0;
    if (ext) begin
      case (code)
        SC_UP:    r = {1'b1, KEY_UP};
        SC_DOWN:  r = {1'b1, KEY_DOWN};
        SC_LEFT:  r = {1'b1, KEY_LEFT};
        SC_RIGHT: r = {1'b1, KEY_RIGHT};
        default:  r = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: r = {1'b1, KEY_SPACE};
        SC_ESC:   r = {1'b1, KEY_ESC};
        SC_ENTER: r = {1'b1, KEY_ENTER};
        SC_P:     r = {1'b1, KEY_P};
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchroniser, falling-edge detect,
// start/data/parity/stop FSM and inter-edge timeout.
module ps2_rx_frame
  import kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall;
  logic                   sdat;
  logic                   timeout;

  frame_state_e state_q, state_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic         strobe_q, strobe_d;
  logic         err_q, err_d;

  assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];

  assign timeout = (state_q != FR_IDLE) && !fall
                && (tmr_q == TMR_MAX);

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (state_q == FR_IDLE || fall || timeout) tmr_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (timeout) begin
      state_d = FR_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        FR_IDLE: begin
          if (!sdat) begin
            state_d = FR_DATA;
            cnt_d   = '0;
          end
        end
        FR_DATA: begin
          shift_d = {sdat, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = FR_PARITY;
        end
        FR_PARITY: begin
          if (^{shift_q, sdat}) begin
            state_d = FR_STOP;
          end else begin
            state_d = FR_IDLE;
            err_d   = 1'b1;
          end
        end
        FR_STOP: begin
          state_d = FR_IDLE;
          if (sdat) strobe_d = 1'b1;
          else      err_d    = 1'b1;
        end
        default: state_d = FR_IDLE;
      endcase
    end
  end

  // Lines idle high, so the synchroniser resets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= FR_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign byte_o   = shift_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: make/break/E0 assembly, held-key bitmap, event buffer.
// Define KBD_EVT_FIFO_EN for a FIFO_DEPTH-entry FWFT event FIFO.
module ps2_key_tracker
  import kbd_pkg::*;
#(
  parameter int NUM_KEYS       = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                PS2_CLK,
  input  logic                PS2_DATA,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_key,
  output logic                evt_make,
  output logic                frame_err,
  output logic                overflow
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .ps2_clk_i (PS2_CLK),
    .ps2_data_i(PS2_DATA),
    .byte_o    (rx_byte),
    .strobe_o  (rx_strobe),
    .err_o     (rx_err)
  );

  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [3:0]          lk;
  logic                push;
  kbd_evt_t            push_evt;
  logic                pop;
  logic                accept;
  logic                ovf_q;
  kbd_evt_t            head;

  assign lk = kbd_lookup(ext_q, rx_byte);

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    down_d   = down_q;
    push     = 1'b0;
    push_evt = '0;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_strobe) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (lk[3] && lk[2:0] == 3'(i)) begin
            if (brk_q && down_q[i]) begin
              down_d[i] = 1'b0;
              push      = 1'b1;
              push_evt  = '{key: lk[2:0], make: 1'b0};
            end else if (!brk_q && !down_q[i]) begin
              down_d[i] = 1'b1;
              push      = 1'b1;
              push_evt  = '{key: lk[2:0], make: 1'b1};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      down_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      down_q <= down_d;
      ovf_q  <= push && !accept;
    end
  end

`ifdef KBD_EVT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  kbd_evt_t  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic      empty;
  logic      full;

  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW])
               && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop    = !empty && evt_ready;
  assign accept = push && (!full || pop);
  assign head   = empty ? '0 : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (accept) wp_q <= wp_q + 1'b1;
      if (pop)    rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem_q[wp_q[AW-1:0]] <= push_evt;
  end

  assign evt_valid = !empty;
`else
  kbd_evt_t evt_q;
  logic     vld_q;

  assign pop    = vld_q && evt_ready;
  assign accept = push && (!vld_q || pop);
  assign head   = evt_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
      vld_q <= 1'b0;
    end else if (accept) begin
      evt_q <= push_evt;
      vld_q <= 1'b1;
    end else if (pop) begin
      vld_q <= 1'b0;
    end
  end

  assign evt_valid = vld_q;
`endif

  assign key_down  = down_q;
  assign evt_key   = head.key;
  assign evt_make  = head.make;
  assign frame_err = rx_err;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker with a
// scan-code-level reference model.
module tb_ps2_key_tracker;

  localparam int NK = 8;
  localparam int SS = 2;
  localparam int TO = 200;
  localparam int FD = 4;
  localparam int H  = 4;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          PS2_CLK = 1'b1;
  logic          PS2_DATA = 1'b1;
  logic          evt_ready = 1'b1;
  logic [NK-1:0] key_down;
  logic          evt_valid;
  logic [2:0]    evt_key;
  logic          evt_make;
  logic          frame_err;
  logic          overflow;

  ps2_key_tracker #(
    .NUM_KEYS      (NK),
    .SYNC_STAGES   (SS),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (FD)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .key_down (key_down),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_make (evt_make),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [3:0] got_q[$];

  logic       stall_q = 1'b0;
  logic [3:0] stall_evt = '0;

  always @(posedge CLK) begin
    if (rst_n) begin
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (evt_valid && evt_ready) got_q.push_back({evt_key, evt_make});
      if (stall_q && evt_valid) begin
        n_tests++;
        if ({evt_key, evt_make} !== stall_evt) begin
          n_fail++;
          $display("FAIL hold_stable got %h want %h",
                   {evt_key, evt_make}, stall_evt);
        end
      end
      stall_q   <= evt_valid && !evt_ready;
      stall_evt <= {evt_key, evt_make};
    end else begin
      stall_q <= 1'b0;
    end
  end

  // Reference model: key table and make/break/prefix rules.
  logic [7:0] code_tab [8] = '{8'h75, 8'h72, 8'h6B, 8'h74,
                               8'h29, 8'h76, 8'h5A, 8'h4D};
  logic [7:0] m_held;
  bit         m_ext;
  bit         m_brk;
  logic [3:0] exp_q[$];

  function automatic void model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (code_tab[k] == b && ((k < 4) == m_ext)) begin
          if (m_brk && m_held[k]) begin
            m_held[k] = 1'b0;
            exp_q.push_back({3'(k), 1'b0});
          end else if (!m_brk && !m_held[k]) begin
            m_held[k] = 1'b1;
            exp_q.push_back({3'(k), 1'b1});
          end
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic ps2_bit(input logic d);
    PS2_DATA = d;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad);
    ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    repeat (H) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [7:0] obs [6];
    string      nm [6];
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    obs = '{8'(key_down), 8'(evt_valid), 8'(evt_key),
            8'(evt_make), 8'(frame_err), 8'(overflow)};
    nm  = '{"key_down", "evt_valid", "evt_key",
            "evt_make", "frame_err", "overflow"};
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (obs[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_%s got %h want 00", nm[i], obs[i]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_press_latency();
    logic [7:0] b;
    b = 8'h29;
    got_q.delete();
    evt_ready = 1'b1;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    PS2_DATA = 1'b1;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge CLK);
      #1;
      if (k == SS + 1) begin
        n_tests++;
        if (key_down[4] !== 1'b0 || evt_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_early got kd=%b v=%b want 0 0",
                   key_down[4], evt_valid);
        end
      end
      if (k == SS + 2) begin
        n_tests++;
        if (key_down[4] !== 1'b1 || evt_valid !== 1'b1
            || {evt_key, evt_make} !== 4'b1001) begin
          n_fail++;
          $display("FAIL latency_on got kd=%b v=%b e=%h want 1 1 9",
                   key_down[4], evt_valid, {evt_key, evt_make});
        end
      end
    end
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (H) @(negedge CLK);
    send_byte(8'hF0, 0);
    send_byte(8'h29, 0);
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== 4'h9 || got_q[1] !== 4'h8
        || key_down !== 8'h00) begin
      n_fail++;
      $display("FAIL space_make_break got %p kd=%h want '{9,8} kd=00",
               got_q, key_down);
    end
  endtask

  task automatic test_arrow();
    got_q.delete();
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    n_tests++;
    if (key_down !== 8'h01) begin
      n_fail++;
      $display("FAIL arrow_held got %h want 01", key_down);
    end
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    send_byte(8'h75, 0);
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== 4'h1 || got_q[1] !== 4'h0
        || key_down !== 8'h00) begin
      n_fail++;
      $display("FAIL arrow_events got %p kd=%h want '{1,0} kd=00",
               got_q, key_down);
    end
  endtask

  task automatic test_typematic();
    got_q.delete();
    repeat (3) send_byte(8'h29, 0);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 4'h9 || key_down !== 8'h10) begin
      n_fail++;
      $display("FAIL typematic got %p kd=%h want '{9} kd=10",
               got_q, key_down);
    end
    send_byte(8'hF0, 0);
    send_byte(8'h29, 0);
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_cnt;
    got_q.delete();
    send_byte(8'h6B, 1);
    n_tests++;
    if (err_cnt !== e0 + 1 || got_q.size() != 0 || key_down !== 8'h00) begin
      n_fail++;
      $display("FAIL parity_err got errs=%0d evts=%0d kd=%h want %0d 0 00",
               err_cnt - e0, got_q.size(), key_down, 1);
    end
    send_byte(8'hE0, 0);
    send_byte(8'h6B, 0);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 4'h5 || key_down !== 8'h04) begin
      n_fail++;
      $display("FAIL parity_recover got %p kd=%h want '{5} kd=04",
               got_q, key_down);
    end
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h6B, 0);
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    got_q.delete();
    send_byte(8'hE0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO - 2 * H) @(negedge CLK);
    n_tests++;
    if (err_cnt !== e0) begin
      n_fail++;
      $display("FAIL timeout_early got errs=%0d want 0", err_cnt - e0);
    end
    repeat (3 * H + 20) @(negedge CLK);
    n_tests++;
    if (err_cnt !== e0 + 1) begin
      n_fail++;
      $display("FAIL timeout_err got errs=%0d want 1", err_cnt - e0);
    end
    send_byte(8'h75, 0);
    n_tests++;
    if (got_q.size() != 0 || key_down !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_ext_clear got %p kd=%h want '{} kd=00",
               got_q, key_down);
    end
    send_byte(8'h76, 0);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 4'hB || key_down !== 8'h20) begin
      n_fail++;
      $display("FAIL timeout_recover got %p kd=%h want '{b} kd=20",
               got_q, key_down);
    end
    send_byte(8'hF0, 0);
    send_byte(8'h76, 0);
  endtask

  task automatic test_overflow();
    int o0;
    o0 = ovf_cnt;
    got_q.delete();
    evt_ready = 1'b0;
    send_byte(8'h29, 0);
    send_byte(8'h76, 0);
    repeat (20) @(negedge CLK);
    n_tests++;
    if (evt_valid !== 1'b1 || {evt_key, evt_make} !== 4'h9
        || key_down !== 8'h30) begin
      n_fail++;
      $display("FAIL ovf_head got v=%b e=%h kd=%h want 1 9 30",
               evt_valid, {evt_key, evt_make}, key_down);
    end
`ifdef KBD_EVT_FIFO_EN
    n_tests++;
    if (ovf_cnt !== o0) begin
      n_fail++;
      $display("FAIL ovf_count got %0d want 0", ovf_cnt - o0);
    end
`else
    n_tests++;
    if (ovf_cnt !== o0 + 1) begin
      n_fail++;
      $display("FAIL ovf_count got %0d want 1", ovf_cnt - o0);
    end
`endif
    evt_ready = 1'b1;
    repeat (6) @(negedge CLK);
`ifdef KBD_EVT_FIFO_EN
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== 4'h9 || got_q[1] !== 4'hB
        || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain got %p v=%b want '{9,b} 0", got_q, evt_valid);
    end
`else
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 4'h9 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain got %p v=%b want '{9} 0", got_q, evt_valid);
    end
`endif
    send_byte(8'hF0, 0);
    send_byte(8'h29, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h76, 0);
  endtask

  task automatic test_reset_midframe();
    got_q.delete();
    evt_ready = 1'b0;
    send_byte(8'h29, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({key_down, evt_valid, evt_key, evt_make, frame_err, overflow}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_async got kd=%h v=%b e=%h fe=%b of=%b want 0",
               key_down, evt_valid, {evt_key, evt_make}, frame_err, overflow);
    end
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    repeat (3) @(negedge CLK);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    repeat (3) @(negedge CLK);
    got_q.delete();
    send_byte(8'h29, 0);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 4'h9 || key_down !== 8'h10) begin
      n_fail++;
      $display("FAIL reset_recover got %p kd=%h want '{9} kd=10",
               got_q, key_down);
    end
  endtask

  task automatic test_random();
    logic [7:0] seq[$];
    logic [7:0] junk [3] = '{8'h1C, 8'h1B, 8'h23};
    int         e0;
    int         exp_err;
    int         k;
    do_reset();
    m_held = '0;
    m_ext  = 0;
    m_brk  = 0;
    exp_q.delete();
    got_q.delete();
    evt_ready = 1'b1;
    e0 = err_cnt;
    exp_err = 0;
    for (int it = 0; it < 50; it++) begin
      int r;
      int badpos;
      seq.delete();
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 7);
      badpos = -1;
      if (r <= 5) begin
        if (k < 4) seq.push_back(8'hE0);
        if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
        seq.push_back(code_tab[k]);
      end else if (r == 6) begin
        if ($urandom_range(0, 1) == 1) seq.push_back(8'hE0);
        if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
        seq.push_back(junk[$urandom_range(0, 2)]);
      end else if (r == 7) begin
        if (k >= 4) seq.push_back(8'hE0);
        seq.push_back(code_tab[k]);
      end else if (r == 8) begin
        if (k < 4) seq.push_back(8'hE0);
        seq.push_back(8'hF0);
        seq.push_back(code_tab[k]);
        badpos = $urandom_range(0, seq.size() - 1);
      end else begin
        seq.push_back(($urandom_range(0, 1) == 1) ? 8'hE0 : 8'hF0);
      end
      for (int j = 0; j < seq.size(); j++) begin
        bit bad;
        bad = (j == badpos);
        if (bad) exp_err++;
        send_byte(seq[j], bad);
        model_byte(seq[j], bad);
        n_tests++;
        if (key_down !== m_held[NK-1:0]) begin
          n_fail++;
          $display("FAIL rand_keydown it=%0d byte=%h got %h want %h",
                   it, seq[j], key_down, m_held[NK-1:0]);
        end
      end
    end
    repeat (10) @(negedge CLK);
    begin
      bit ok;
      ok = (got_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) ok = 0;
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_events got %0d evts want %0d evts",
                 got_q.size(), exp_q.size());
      end
    end
    n_tests++;
    if (err_cnt - e0 != exp_err) begin
      n_fail++;
      $display("FAIL rand_errs got %0d want %0d", err_cnt - e0, exp_err);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press_latency();
    test_arrow();
    test_typematic();
    test_parity();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
